// File: rtl/register_univ_nbit_if.sv
// Bus bundle for register_univ_nbit: control, data and status of one universal register.
interface register_univ_nbit_if #(
    parameter int WIDTH = 8
);
    logic             Ce;
    logic [2:0]       mode;
    logic [WIDTH-1:0] Din;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] Dout;
    logic             cout;
    logic             zero;

    modport master (
        output Ce, mode, Din, sin_r, sin_l,
        input  Dout, cout, zero
    );

    modport slave (
        input  Ce, mode, Din, sin_r, sin_l,
        output Dout, cout, zero
    );
endinterface

// File: rtl/register_univ_nbit.sv
// WIDTH-bit universal register: hold/load/shift/rotate/inc/dec with registered cout and zero flag.
// Optional macro REGISTER_UNIV_SAT_EN makes inc/dec saturate instead of wrapping.
module register_univ_nbit #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    register_univ_nbit_if.slave bus
);
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROTL = 3'b100,
        MODE_ROTR = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_t;

    localparam logic [WIDTH-1:0] RESET_DATA = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH:0]   ONE_EXT    = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_n;
    logic             cout_q;
    logic             cout_n;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    mode_t            op;

    assign op   = mode_t'(bus.mode);
    assign sum  = {1'b0, data_q} + ONE_EXT;
    assign diff = {1'b0, data_q} - ONE_EXT;

    // The top bit of the W+1-bit intermediates is the carry (inc) or borrow (dec).
    always_comb begin
        data_n = data_q;
        cout_n = cout_q;
        case (op)
            MODE_HOLD: begin
                data_n = data_q;
                cout_n = cout_q;
            end
            MODE_LOAD: begin
                data_n = bus.Din;
                cout_n = 1'b0;
            end
            MODE_SHL: begin
                data_n = {data_q[WIDTH-2:0], bus.sin_r};
                cout_n = data_q[WIDTH-1];
            end
            MODE_SHR: begin
                data_n = {bus.sin_l, data_q[WIDTH-1:1]};
                cout_n = data_q[0];
            end
            MODE_ROTL: begin
                data_n = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                cout_n = data_q[WIDTH-1];
            end
            MODE_ROTR: begin
                data_n = {data_q[0], data_q[WIDTH-1:1]};
                cout_n = data_q[0];
            end
            MODE_INC: begin
`ifdef REGISTER_UNIV_SAT_EN
                data_n = sum[WIDTH] ? data_q : sum[WIDTH-1:0];
`else
                data_n = sum[WIDTH-1:0];
`endif
                cout_n = sum[WIDTH];
            end
            MODE_DEC: begin
`ifdef REGISTER_UNIV_SAT_EN
                data_n = diff[WIDTH] ? data_q : diff[WIDTH-1:0];
`else
                data_n = diff[WIDTH-1:0];
`endif
                cout_n = diff[WIDTH];
            end
            default: begin
                data_n = data_q;
                cout_n = cout_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_DATA;
            cout_q <= 1'b0;
        end else if (bus.Ce) begin
            data_q <= data_n;
            cout_q <= cout_n;
        end
    end

    assign bus.Dout = data_q;
    assign bus.cout = cout_q;
    assign bus.zero = (data_q == '0);
endmodule

// File: tb/tb_register_univ_nbit.sv
// Self-checking bench for register_univ_nbit (WIDTH=8, RESET_VAL=8'hA5) against an arithmetic model.
module tb_register_univ_nbit;
    localparam int W   = 8;
    localparam int MOD = 2 ** W;
    localparam int RV  = 'hA5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    register_univ_nbit_if #(.WIDTH(W)) bus ();

    register_univ_nbit #(
        .WIDTH     (W),
        .RESET_VAL (32'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit check_en     = 1'b0;

    int m_data = RV;
    int m_cout = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour in plain integer arithmetic on the value range 0..2^W-1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data = RV;
            m_cout = 0;
        end else if (bus.Ce) begin
            case (int'(bus.mode))
                1: begin m_data = int'(bus.Din); m_cout = 0; end
                2: begin m_cout = m_data / (MOD / 2); m_data = (m_data * 2) % MOD + int'(bus.sin_r); end
                3: begin m_cout = m_data % 2; m_data = m_data / 2 + int'(bus.sin_l) * (MOD / 2); end
                4: begin m_cout = m_data / (MOD / 2); m_data = (m_data * 2) % MOD + m_cout; end
                5: begin m_cout = m_data % 2; m_data = m_data / 2 + m_cout * (MOD / 2); end
                6: begin
                    if (m_data == MOD - 1) begin
`ifdef REGISTER_UNIV_SAT_EN
                        m_data = MOD - 1;
`else
                        m_data = 0;
`endif
                        m_cout = 1;
                    end else begin
                        m_data = m_data + 1;
                        m_cout = 0;
                    end
                end
                7: begin
                    if (m_data == 0) begin
`ifdef REGISTER_UNIV_SAT_EN
                        m_data = 0;
`else
                        m_data = MOD - 1;
`endif
                        m_cout = 1;
                    end else begin
                        m_data = m_data - 1;
                        m_cout = 0;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_output("model_dout", int'(bus.Dout), m_data);
            check_output("model_cout", int'(bus.cout), m_cout);
            check_output("model_zero", int'(bus.zero), (m_data == 0) ? 1 : 0);
        end
    end

    // Drives one operation 2 time units after an edge, then returns 2 units after the edge that applies it.
    task automatic apply_stimulus(input bit ce, input int mode, input int din, input bit sr, input bit sl);
        bus.Ce    = ce;
        bus.mode  = 3'(mode);
        bus.Din   = W'(din);
        bus.sin_r = sr;
        bus.sin_l = sl;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_state(input string name, input int d, input int c);
        check_output({name, "_dout"}, int'(bus.Dout), d);
        check_output({name, "_cout"}, int'(bus.cout), c);
        check_output({name, "_zero"}, int'(bus.zero), (d == 0) ? 1 : 0);
    endtask

    initial begin
        bus.Ce = 1'b0; bus.mode = 3'd0; bus.Din = '0; bus.sin_r = 1'b0; bus.sin_l = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        expect_state("reset", 'hA5, 0);
        rst = 1'b0;
        check_en = 1'b1;

        apply_stimulus(1, 1, 'h5A, 0, 0);
        expect_state("load5a", 'h5A, 0);
        rst = 1'b1;
        #1;
        expect_state("async_rst", 'hA5, 0);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 'h3C, 0, 0);
        expect_state("ce_off", 'hA5, 0);

        apply_stimulus(1, 1, 'h81, 0, 0);
        apply_stimulus(1, 2, 0, 0, 0);
        expect_state("shl", 'h02, 1);
        apply_stimulus(1, 3, 0, 0, 1);
        expect_state("shr", 'h81, 0);

        apply_stimulus(1, 1, 'h01, 0, 0);
        apply_stimulus(1, 5, 0, 0, 0);
        expect_state("rotr", 'h80, 1);
        apply_stimulus(1, 4, 0, 0, 0);
        apply_stimulus(1, 4, 0, 0, 0);
        expect_state("rotl2", 'h02, 0);

`ifdef REGISTER_UNIV_SAT_EN
        apply_stimulus(1, 1, 'hFF, 0, 0);
        apply_stimulus(1, 6, 0, 0, 0);
        expect_state("inc_sat", 'hFF, 1);
        apply_stimulus(1, 1, 'h00, 0, 0);
        apply_stimulus(1, 7, 0, 0, 0);
        expect_state("dec_sat", 'h00, 1);
`else
        apply_stimulus(1, 1, 'hFE, 0, 0);
        apply_stimulus(1, 6, 0, 0, 0);
        expect_state("inc_fe", 'hFF, 0);
        apply_stimulus(1, 6, 0, 0, 0);
        expect_state("inc_wrap", 'h00, 1);
        apply_stimulus(1, 7, 0, 0, 0);
        expect_state("dec_wrap", 'hFF, 1);
`endif
        apply_stimulus(1, 0, 'h11, 1, 1);
        expect_state("hold", `ifdef REGISTER_UNIV_SAT_EN 'h00 `else 'hFF `endif, 1);

        apply_stimulus(1, 1, 'h10, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 6, 0, 0, 0);
        expect_state("inc3", 'h13, 0);
        rst = 1'b1;
        #1;
        expect_state("rst_mid_op", 'hA5, 0);
        apply_stimulus(1, 6, 0, 0, 0);
        expect_state("rst_held", 'hA5, 0);
        rst = 1'b0;

        // Mixed directed sweep that exercises every mode back to back.
        for (int i = 0; i < 24; i++)
            apply_stimulus((i % 5) != 4, i % 8, (i * 37 + 11) % MOD, bit'(i % 2), bit'((i / 2) % 2));

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
